// File: rtl/case_4_mul_pipe_hs_pkg.sv
// Shared definitions for the pipelined handshake multiplier: signedness mode
// encodings, the full-product width helper and the saturating clamp used when
// the design is built with OUTPUT_SAT_EN.
package case_4_mul_pkg;

  // bit0 = operand A signed, bit1 = operand B signed
  typedef enum logic [1:0] {
    MODE_UU = 2'b00,
    MODE_SU = 2'b01,
    MODE_US = 2'b10,
    MODE_SS = 2'b11
  } mul_mode_e;

  // Width of the exact product of two operands that were each widened by one bit
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

`ifdef OUTPUT_SAT_EN
  // Clamp a signed product into a w-bit range; returns {clamped, value}
  function automatic logic [64:0] clamp_result(input logic signed [63:0] p,
                                               input int w,
                                               input logic isUnsigned);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (isUnsigned) begin
      hi = (64'sd1 <<< w) - 64'sd1;
      lo = 64'sd0;
    end else begin
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
    end
    if (p > hi) begin
      return {1'b1, hi};
    end else if (p < lo) begin
      return {1'b1, lo};
    end
    return {1'b0, p};
  endfunction
`endif

endpackage

// File: rtl/case_4_mul_pipe_hs_if.sv
// Operand/result handshake bundle of the pipelined multiplier. The master is
// the producer of operands and consumer of results; the slave is the multiplier.
interface case_4_mul_pipe_hs_if #(
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic [1:0]            in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic                  out_sat;

  modport master (
    output in_valid, din0, din1, in_mode, out_ready,
    input  in_ready, out_valid, dout, out_sat
  );

  modport slave (
    input  in_valid, din0, din1, in_mode, out_ready,
    output in_ready, out_valid, dout, out_sat
  );
endinterface

// File: rtl/case_4_mul_pipe_hs_stage.sv
// One valid/ready register slice. The slice accepts a new word whenever it is
// empty or its downstream neighbour is taking the word it holds, so bubbles
// collapse under backpressure and a full pipe can still move every cycle.
module case_4_mul_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         ready_i
);
  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Load when empty or when the held word is leaving; data only moves with a valid word
  always_comb begin
    ready_o = !valid_q || ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  // Slice register; reset empties the slice and clears the held word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/case_4_mul_pipe_hs.sv
// Pipelined integer multiplier with valid/ready on both sides and a per-
// transaction signedness mode. Operands are widened by one bit (sign or zero
// per mode), multiplied exactly, reduced to dout_WIDTH and carried through
// NUM_STAGE handshake slices. Build option OUTPUT_SAT_EN replaces truncation
// with a clamp to the signed/unsigned result range and reports it on out_sat.
module case_4_mul_pipe_hs
  import case_4_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  case_4_mul_pipe_hs_if.slave bus
);
  localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int SW = dout_WIDTH + 1;

  logic signed [din0_WIDTH:0] opA;
  logic signed [din1_WIDTH:0] opB;
  logic signed [PW-1:0]       prod;
  logic [dout_WIDTH-1:0]      resDout;
  logic                       resSat;
  logic [SW-1:0]              resWord;

  logic                       validC [NUM_STAGE+1];
  logic                       readyC [NUM_STAGE+1];
  logic [SW-1:0]              dataC  [NUM_STAGE+1];

  // Widen each operand per its mode bit and form the exact signed product
  always_comb begin
    opA  = {bus.in_mode[0] & bus.din0[din0_WIDTH-1], bus.din0};
    opB  = {bus.in_mode[1] & bus.din1[din1_WIDTH-1], bus.din1};
    prod = PW'(opA) * PW'(opB);
  end

`ifdef OUTPUT_SAT_EN
  logic [64:0] clampRes;

  // Clamp into the range of the result class: unsigned only for u*u
  always_comb begin
    clampRes = clamp_result(64'(prod), dout_WIDTH, bus.in_mode == MODE_UU);
    resDout  = dout_WIDTH'(clampRes);
    resSat   = clampRes[64];
  end
`else
  // Plain wrap: keep the low bits of the product, never flag a clamp
  always_comb begin
    resDout = dout_WIDTH'(prod);
    resSat  = 1'b0;
  end
`endif

  assign resWord   = {resSat, resDout};
  assign validC[0] = bus.in_valid;
  assign dataC[0]  = resWord;
  assign readyC[NUM_STAGE] = bus.out_ready;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : gStage
    case_4_mul_pipe_stage #(.W(SW)) uStage (
      .clk     (clk),
      .reset   (reset),
      .valid_i (validC[k]),
      .data_i  (dataC[k]),
      .ready_o (readyC[k]),
      .valid_o (validC[k+1]),
      .data_o  (dataC[k+1]),
      .ready_i (readyC[k+1])
    );
  end

  assign bus.in_ready  = readyC[0] & ~reset;
  assign bus.out_valid = validC[NUM_STAGE];
  assign bus.out_sat   = dataC[NUM_STAGE][SW-1];
  assign bus.dout      = dataC[NUM_STAGE][dout_WIDTH-1:0];
endmodule

// File: tb/tb_case_4_mul_pipe_hs.sv
// Bench for case_4_mul_pipe_hs: directed table of arithmetic cases on a
// 3-stage instance, stall/reset sequences, and randomized traffic on 1- and
// 4-stage instances checked against an integer reference model.
module tb_case_4_mul_pipe_hs;
  localparam int NTX = 10000;
`ifdef OUTPUT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   doneCount = 0;
  bit   startRand = 1'b0;

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] a;
    logic [4:0] b;
    logic [8:0] expWrap;
    logic [8:0] expSat;
  } vec_t;

  vec_t vecs [15];

  case_4_mul_pipe_hs_if #(.din0_WIDTH(8), .din1_WIDTH(5), .dout_WIDTH(8)) bus ();

  case_4_mul_pipe_hs #(
    .ID(1), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(5), .dout_WIDTH(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock shared by all instances
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Arithmetic meaning of the operands, then exact product, then wrap or clamp
  function automatic logic [8:0] refModel(input logic [1:0] mode, input logic [7:0] a, input logic [4:0] b);
    int av;
    int bv;
    int p;
    int lo;
    int hi;
    logic [31:0] pw;
    av = (mode[0] && a[7]) ? int'(a) - 256 : int'(a);
    bv = (mode[1] && b[4]) ? int'(b) - 32 : int'(b);
    p  = av * bv;
    if (SAT) begin
      lo = (mode == 2'b00) ? 0 : -128;
      hi = (mode == 2'b00) ? 255 : 127;
      if (p > hi) begin
        pw = hi;
        return {1'b1, pw[7:0]};
      end
      if (p < lo) begin
        pw = lo;
        return {1'b1, pw[7:0]};
      end
    end
    pw = p;
    return {1'b0, pw[7:0]};
  endfunction

  // Send one transaction with out_ready high and check latency and result
  task automatic applyStimulus(input string name, input logic [1:0] mode, input logic [7:0] a,
                               input logic [4:0] b, input logic [8:0] expRes);
    int lat;
    @(negedge clk);
    bus.in_mode   = mode;
    bus.din0      = a;
    bus.din1      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 checkOutput({name, "_inReady"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'd3);
    checkOutput({name, "_result"}, 32'({bus.out_sat, bus.dout}), 32'(expRes));
  endtask

  // Directed tests on the 3-stage instance
  initial begin
    logic [8:0] expQ [$];
    logic [8:0] e;
    logic [7:0] ta [6];
    logic [4:0] tb [6];
    logic [1:0] tm [6];
    int sent;
    int got;

    vecs[0]  = '{"ssM7x3",    2'b11, 8'hF9, 5'h03, 9'h0EB, 9'h0EB};
    vecs[1]  = '{"ss1500",    2'b11, 8'h64, 5'h0F, 9'h0DC, 9'h17F};
    vecs[2]  = '{"uu6200",    2'b00, 8'hC8, 5'h1F, 9'h038, 9'h1FF};
    vecs[3]  = '{"suM1x31",   2'b01, 8'hFF, 5'h1F, 9'h0E1, 9'h0E1};
    vecs[4]  = '{"us255xM1",  2'b10, 8'hFF, 5'h1F, 9'h001, 9'h180};
    vecs[5]  = '{"uu255x31",  2'b00, 8'hFF, 5'h1F, 9'h0E1, 9'h1FF};
    vecs[6]  = '{"ssM128xM16",2'b11, 8'h80, 5'h10, 9'h000, 9'h17F};
    vecs[7]  = '{"ssM128x15", 2'b11, 8'h80, 5'h0F, 9'h080, 9'h180};
    vecs[8]  = '{"uuZero",    2'b00, 8'h00, 5'h1F, 9'h000, 9'h000};
    vecs[9]  = '{"ssMaxPos",  2'b11, 8'h7F, 5'h01, 9'h07F, 9'h07F};
    vecs[10] = '{"ssMinNeg",  2'b11, 8'h80, 5'h01, 9'h080, 9'h080};
    vecs[11] = '{"suMinNeg",  2'b01, 8'h80, 5'h01, 9'h080, 9'h080};
    vecs[12] = '{"uuMax",     2'b00, 8'hFF, 5'h01, 9'h0FF, 9'h0FF};
    vecs[13] = '{"usM16",     2'b10, 8'h01, 5'h10, 9'h0F0, 9'h0F0};
    vecs[14] = '{"uu256",     2'b00, 8'h10, 5'h10, 9'h000, 9'h1FF};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.din0      = '0;
    bus.din1      = '0;
    bus.in_mode   = 2'b00;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstDout", 32'(bus.dout), 32'd0);
    checkOutput("rstOutSat", 32'(bus.out_sat), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("relInReady", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b,
                    SAT ? vecs[i].expSat : vecs[i].expWrap);
    end

    // Six back-to-back transactions, consumer stalled on cycles 2..5
    for (int i = 0; i < 6; i++) begin
      ta[i] = 8'(37 * i + 90);
      tb[i] = 5'(7 * i + 9);
      tm[i] = 2'(i);
      expQ.push_back(refModel(tm[i], ta[i], tb[i]));
    end
    sent = 0;
    got = 0;
    for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 2 && cyc <= 5);
      bus.in_valid  = (sent < 6);
      bus.din0      = ta[sent % 6];
      bus.din1      = tb[sent % 6];
      bus.in_mode   = tm[sent % 6];
      #1;
      if (cyc == 3) checkOutput("stallInReadyC3", 32'(bus.in_ready), 32'd1);
      if (cyc == 4) checkOutput("stallInReadyC4", 32'(bus.in_ready), 32'd0);
      if (cyc == 5) checkOutput("stallInReadyC5", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && !bus.out_ready && expQ.size() > 0) begin
        checkOutput("stallHeld", 32'({bus.out_sat, bus.dout}), 32'(expQ[0]));
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        e = (expQ.size() > 0) ? expQ.pop_front() : 9'h1FF;
        checkOutput("stallOrder", 32'({bus.out_sat, bus.dout}), 32'(e));
        got++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("stallAllOut", 32'(got), 32'd6);

    // Reset while two transactions are in flight, one presented at the output
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'b11;
    bus.din0      = 8'd5;
    bus.din1      = 5'd3;
    @(negedge clk);
    bus.din0 = 8'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkOutput("preRstOutValid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midRstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midRstDout", 32'(bus.dout), 32'd0);
    checkOutput("midRstInReady", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("postRstInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("postRstOutValid", 32'(bus.out_valid), 32'd0);
    applyStimulus("afterRst", vecs[0].mode, vecs[0].a, vecs[0].b,
                  SAT ? vecs[0].expSat : vecs[0].expWrap);

    startRand = 1'b1;
    wait (doneCount == 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Randomized traffic on 1-stage and 4-stage instances
  for (genvar g = 0; g < 2; g++) begin : gRand
    localparam int NSG = (g == 0) ? 1 : 4;

    case_4_mul_pipe_hs_if #(.din0_WIDTH(8), .din1_WIDTH(5), .dout_WIDTH(8)) rb ();

    case_4_mul_pipe_hs #(
      .ID(g + 2), .NUM_STAGE(NSG), .din0_WIDTH(8), .din1_WIDTH(5), .dout_WIDTH(8)
    ) uRand (
      .clk   (clk),
      .reset (reset),
      .bus   (rb)
    );

    initial begin
      logic [8:0] q [$];
      logic [8:0] e;
      logic [8:0] held;
      logic       heldValid;
      int         sent;
      rb.in_valid  = 1'b0;
      rb.out_ready = 1'b1;
      rb.din0      = '0;
      rb.din1      = '0;
      rb.in_mode   = 2'b00;
      wait (startRand);
      sent = 0;
      heldValid = 1'b0;
      for (int cyc = 0; cyc < 40000 && !(sent == NTX && q.size() == 0); cyc++) begin
        @(negedge clk);
        rb.in_valid  = (sent < NTX) && ($urandom_range(0, 3) != 0);
        rb.din0      = 8'($urandom);
        rb.din1      = 5'($urandom);
        rb.in_mode   = 2'($urandom);
        rb.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (heldValid) begin
          checkOutput($sformatf("randHold%0d", NSG), 32'({rb.out_valid, rb.out_sat, rb.dout}),
                      32'({1'b1, held}));
        end
        heldValid = 1'b0;
        if (rb.in_valid && rb.in_ready) begin
          q.push_back(refModel(rb.in_mode, rb.din0, rb.din1));
          sent++;
        end
        if (rb.out_valid) begin
          if (q.size() == 0) begin
            checkOutput($sformatf("randSpurious%0d", NSG), 32'd1, 32'd0);
          end else if (rb.out_ready) begin
            e = q.pop_front();
            checkOutput($sformatf("randResult%0d", NSG), 32'({rb.out_sat, rb.dout}), 32'(e));
          end else begin
            held = {rb.out_sat, rb.dout};
            heldValid = 1'b1;
          end
        end
      end
      checkOutput($sformatf("randDrained%0d", NSG), 32'(q.size() + (NTX - sent)), 32'd0);
      doneCount++;
    end
  end
endmodule
